serial_compare_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit unsigned operands by stepping a 2-bit magnitude-compare slice across them, MSB pair first.
- Stops at the first unequal pair.
- Reports greater / equal / less with a start/done handshake and a count of slice steps used.
- Sits between a front-end that loads operands (switches / register file) and the result LEDs/consumers in the lab datapath.

---
 rtl/serial_compare_ctrl_if.sv | 26 ++
 rtl/serial_compare_ctrl.sv | 110 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Handshake and operand/result bundle between an operand front-end and the
// serial magnitude comparator.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH/2) + 1
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    steps;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, steps
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, steps
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Unsigned magnitude comparator that walks a 2-bit compare slice from the MSB
// pair downward and stops at the first unequal pair.
//
// state | meaning
// IDLE  | waiting for start; last result and step count held
// CMP   | one slice examined per cycle, operands shift left by 2 on a tie
// DONE  | result valid, done pulses for this single cycle
module serial_compare_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH/2) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_compare_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH/2);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             busy_r;
  logic             done_r;
  logic             gt_r;
  logic             eq_r;
  logic             lt_r;
  logic [CW-1:0]    steps_r;

  logic             a1, a0, b1, b0;
  logic             slice_gt, slice_lt;
  logic [CW-1:0]    steps_nxt;

  assign a1 = ra[WIDTH-1];
  assign a0 = ra[WIDTH-2];
  assign b1 = rb[WIDTH-1];
  assign b0 = rb[WIDTH-2];

  assign slice_gt  = (a1 & ~b1) | (a0 & ~b1 & ~b0) | (a1 & a0 & ~b0);
  assign slice_lt  = (b1 & ~a1) | (b0 & ~a1 & ~a0) | (b1 & b0 & ~a0);
  assign steps_nxt = steps_r + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      steps_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ra      <= bus.a;
            rb      <= bus.b;
            steps_r <= '0;
            gt_r    <= 1'b0;
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            busy_r  <= 1'b1;
            state   <= CMP;
          end
        end
        CMP: begin
          steps_r <= steps_nxt;
          if (slice_gt) begin
            gt_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else if (slice_lt) begin
            lt_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else if (steps_nxt == LAST_STEP) begin
            eq_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            ra <= {ra[WIDTH-3:0], 2'b00};
            rb <= {rb[WIDTH-3:0], 2'b00};
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.gt    = gt_r;
  assign bus.eq    = eq_r;
  assign bus.lt    = lt_r;
  assign bus.steps = steps_r;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: directed cases plus random
// operand pairs checked against an arithmetic reference model.
module tb_serial_compare_ctrl;
  localparam int WIDTH = 8;
  localparam int NSL   = WIDTH / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags from whole-operand arithmetic; step count = index of first
  // differing 2-bit pair counted from the MSB, or all pairs on a tie.
  task automatic ref_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         output logic egt, output logic eeq, output logic elt,
                         output int esteps);
    int sa, sb;
    egt = (av > bv);
    eeq = (av == bv);
    elt = (av < bv);
    esteps = NSL;
    for (int k = 0; k < NSL; k++) begin
      sa = (int'(av) >> (WIDTH - 2 - 2*k)) & 3;
      sb = (int'(bv) >> (WIDTH - 2 - 2*k)) & 3;
      if (sa != sb) begin
        esteps = k + 1;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the DUT in IDLE; returns just after the
  // DONE->IDLE edge.
  task automatic do_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit inject, input string tag);
    logic egt, eeq, elt;
    int   esteps;
    int   m;
    bit   seen;
    ref_cmp(av, bv, egt, eeq, elt, esteps);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    step();
    bus.start = inject;
    bus.a     = inject ? 8'hFF : WIDTH'($urandom);
    bus.b     = inject ? 8'h00 : WIDTH'($urandom);
    chk({tag, ".busy_accept"}, bus.busy, 1);
    chk({tag, ".flags_cleared"}, {bus.gt, bus.eq, bus.lt}, 0);
    chk({tag, ".steps_cleared"}, bus.steps, 0);
    seen = 1'b0;
    m    = 0;
    for (int k = 1; k <= NSL + 2; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        m    = k;
        break;
      end
      chk({tag, ".busy_in_cmp"}, bus.busy, 1);
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, m, esteps);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    chk({tag, ".flags"}, {bus.gt, bus.eq, bus.lt}, {egt, eeq, elt});
    chk({tag, ".steps"}, bus.steps, esteps);
    step();
    chk({tag, ".done_one_cycle"}, bus.done, 0);
    chk({tag, ".flags_held"}, {bus.gt, bus.eq, bus.lt}, {egt, eeq, elt});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int pulses, last;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    step();
    step();
    chk("reset.outputs", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt}, 0);
    chk("reset.steps", bus.steps, 0);
    rst = 1'b0;
    step();

    do_cmp(8'hA5, 8'h5A, 1'b0, "a5_5a");
    do_cmp(8'h3C, 8'h3C, 1'b0, "3c_3c");
    do_cmp(8'h40, 8'h70, 1'b0, "40_70");
    do_cmp(8'h12, 8'h13, 1'b0, "12_13");
    do_cmp(8'h00, 8'h00, 1'b1, "ignored_start");

    // Reset during the second CMP cycle aborts the comparison.
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h3D;
    step();
    bus.start = 1'b0;
    step();
    chk("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.outputs", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt}, 0);
    chk("abort.steps", bus.steps, 0);
    step();
    chk("abort.no_done", {bus.busy, bus.done}, 0);
    do_cmp(8'h3C, 8'h3D, 1'b0, "after_abort");

    // Start held high: a new gt result every m+2 = 3 cycles.
    bus.start = 1'b1;
    bus.a     = 8'hC0;
    bus.b     = 8'h40;
    pulses    = 0;
    last      = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.done) begin
        pulses++;
        chk("hold.flags", {bus.gt, bus.eq, bus.lt}, 3'b100);
        chk("hold.steps", bus.steps, 1);
        if (last > 0) chk("hold.period", i - last, 3);
        last = i;
      end else if (!bus.busy) begin
        chk("hold.flags_idle", {bus.gt, bus.eq, bus.lt}, 3'b100);
      end
    end
    chk("hold.pulses", pulses, 4);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("hold.settled", {bus.busy, bus.done}, 0);

    // Random pairs, biased so deep and full-length compares occur.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      endcase
      do_cmp(ra, rb, 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
